// File: rtl/spi_master_shifter.sv
// SPI mode-0 master byte engine: one byte per chip-select frame, MSB first,
// full duplex, with configurable SCLK half-period and chip-select idle gap.
module spi_master_shifter #(
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int CS_INACTIVE_CLKS  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dv_mosi,
  input  logic [7:0] data_mosi,
  output logic       ready,
  output logic       dv_miso,
  output logic [7:0] data_miso,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_cs_n
);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

  localparam int MAXV = (CLKS_PER_HALF_BIT > CS_INACTIVE_CLKS) ? CLKS_PER_HALF_BIT : CS_INACTIVE_CLKS;
  localparam int CW   = $clog2(MAXV + 1);
  localparam logic [CW-1:0] H_LAST = CW'(CLKS_PER_HALF_BIT - 1);
  localparam logic [CW-1:0] G_LAST = CW'(CS_INACTIVE_CLKS - 1);
  // Ready is raised one cycle before the gap ends so an accept lands exactly
  // when the gap expires; with a one-cycle gap it must already rise in TRAIL.
  localparam logic [CW-1:0] G_PRE  = CW'(CS_INACTIVE_CLKS - 2);
  localparam logic READY_EARLY = (CS_INACTIVE_CLKS == 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [3:0]      edge_cnt;
  logic [7:0]      tx_shift;
  logic [7:0]      rx_shift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      edge_cnt  <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      ready     <= 1'b1;
      dv_miso   <= 1'b0;
      data_miso <= '0;
      spi_sclk  <= 1'b0;
      spi_mosi  <= 1'b0;
      spi_cs_n  <= 1'b1;
    end else begin
      dv_miso <= 1'b0;
      if (ready && dv_mosi) begin
        tx_shift <= data_mosi;
        spi_mosi <= data_mosi[7];
        spi_cs_n <= 1'b0;
        ready    <= 1'b0;
        cnt      <= '0;
        edge_cnt <= '0;
        state    <= LEAD;
      end else begin
        case (state)
          IDLE: ;
          LEAD: begin
            if (cnt == H_LAST) begin
              cnt      <= '0;
              spi_sclk <= 1'b1;
              rx_shift <= {rx_shift[6:0], spi_miso};
              edge_cnt <= '0;
              state    <= SHIFT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          SHIFT: begin
            if (cnt == H_LAST) begin
              cnt <= '0;
              // edge_cnt == 15: all 16 edges done and the final low phase has elapsed
              if (edge_cnt == 4'd15) begin
                state <= TRAIL;
              end else begin
                edge_cnt <= edge_cnt + 1'b1;
                spi_sclk <= ~spi_sclk;
                if (!spi_sclk) begin
                  rx_shift <= {rx_shift[6:0], spi_miso};
                end else if (edge_cnt != 4'd14) begin
                  spi_mosi <= tx_shift[6];
                  tx_shift <= {tx_shift[6:0], 1'b0};
                end
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          TRAIL: begin
            if (cnt == H_LAST) begin
              cnt       <= '0;
              spi_cs_n  <= 1'b1;
              spi_mosi  <= 1'b0;
              data_miso <= rx_shift;
              dv_miso   <= 1'b1;
              ready     <= READY_EARLY;
              state     <= GAP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          GAP: begin
            if (cnt == G_LAST) begin
              cnt   <= '0;
              ready <= 1'b1;
              state <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
              if (cnt == G_PRE) ready <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_master_shifter.sv
// Scoreboard bench for spi_master_shifter: directed frames, loopback and slave model.
module tb_spi_master_shifter;
  localparam int H = 2;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       dv_mosi = 1'b0;
  logic [7:0] data_mosi = 8'h00;
  logic       ready, dv_miso, spi_sclk, spi_mosi, spi_cs_n;
  logic [7:0] data_miso;
  logic       spi_miso;

  logic       loop_en = 1'b1;
  logic [7:0] slave_byte = 8'h00;
  logic [7:0] sl_sr = 8'h00;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rise_cnt = 0;
  logic [7:0] mosi_bits = 8'h00;
  logic prev_dv = 1'b0;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
    int         acc;
  } exp_t;
  exp_t sb[$];

  spi_master_shifter #(.CLKS_PER_HALF_BIT(H), .CS_INACTIVE_CLKS(G)) dut (
    .clk(clk), .reset(reset), .dv_mosi(dv_mosi), .data_mosi(data_mosi),
    .ready(ready), .dv_miso(dv_miso), .data_miso(data_miso),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave: presents MSB on CS assert, advances on SCLK falling edges
  always @(negedge spi_cs_n) begin
    sl_sr = slave_byte;
    rise_cnt = 0;
  end
  always @(negedge spi_sclk) if (!spi_cs_n) sl_sr = {sl_sr[6:0], 1'b0};
  always @(posedge spi_sclk) begin
    rise_cnt = rise_cnt + 1;
    mosi_bits = {mosi_bits[6:0], spi_mosi};
  end
  assign spi_miso = loop_en ? spi_mosi : sl_sr[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  // Monitor: pops the scoreboard on every dv_miso pulse
  always @(negedge clk) begin
    if (dv_miso) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_dv: got data %0h, expected no dv_miso", data_miso);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("[TB] frame tx=%0h rx=%0h latency=%0d", e.tx, data_miso, cyc - e.acc);
        check("data_miso", {24'h0, data_miso}, {24'h0, e.rx});
        check("latency", cyc - e.acc, 18 * H);
        check("sclk_rises", rise_cnt, 8);
        check("mosi_bits", {24'h0, mosi_bits}, {24'h0, e.tx});
        check("dv_one_cycle", {31'h0, prev_dv}, 32'h0);
      end
    end
    prev_dv <= dv_miso;
  end

  task automatic send(input logic [7:0] b, input logic [7:0] exp_rx, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: ready got 0 expected 1");
      return;
    end
    dv_mosi = 1'b1;
    data_mosi = b;
    @(negedge clk);
    dv_mosi = 1'b0;
    data_mosi = 8'hEE;
    if (push) sb.push_back('{b, exp_rx, cyc});
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((sb.size() != 0 || !ready) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", {31'h0, (sb.size() != 0 || !ready)}, 32'h0);
  endtask

  task automatic wait_rises(input int k);
    int n;
    n = 0;
    while (rise_cnt < k && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("rise_wait", {31'h0, (rise_cnt < k)}, 32'h0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, {31'h0, ready}, 32'h1);
    check({tag, "_cs_n"}, {31'h0, spi_cs_n}, 32'h1);
    check({tag, "_sclk"}, {31'h0, spi_sclk}, 32'h0);
    check({tag, "_mosi"}, {31'h0, spi_mosi}, 32'h0);
    check({tag, "_dv"}, {31'h0, dv_miso}, 32'h0);
    check({tag, "_data"}, {24'h0, data_miso}, 32'h0);
  endtask

  initial begin
    int hi;
    int n;
    // 1: reset in idle
    repeat (3) @(negedge clk);
    check_reset_state("rst_idle");
    reset = 1'b0;

    // 2: loopback A5
    loop_en = 1'b1;
    send(8'hA5, 8'hA5, 1'b1);
    wait_done();

    // 1b: reset after a frame clears data_miso
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_state("rst_post");
    @(negedge clk);
    reset = 1'b0;

    // 3: slave returns 3C while AA goes out
    loop_en = 1'b0;
    slave_byte = 8'h3C;
    send(8'hAA, 8'h3C, 1'b1);
    wait_done();

    // 4: dv_mosi while busy is ignored
    slave_byte = 8'h96;
    send(8'h0F, 8'h96, 1'b1);
    wait_rises(4);
    dv_mosi = 1'b1;
    data_mosi = 8'h55;
    check("busy_ready", {31'h0, ready}, 32'h0);
    @(negedge clk);
    dv_mosi = 1'b0;
    wait_done();
    repeat (50) @(negedge clk);

    // 5: reset mid-frame aborts
    loop_en = 1'b1;
    send(8'hC3, 8'hC3, 1'b0);
    wait_rises(3);
    #1 reset = 1'b1;
    #1;
    check("abort_cs_n", {31'h0, spi_cs_n}, 32'h1);
    check("abort_sclk", {31'h0, spi_sclk}, 32'h0);
    check("abort_dv", {31'h0, dv_miso}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    send(8'h0F, 8'h0F, 1'b1);
    wait_done();

    // 6: dv_mosi held high, back-to-back frames
    @(negedge clk);
    dv_mosi = 1'b1;
    data_mosi = 8'h81;
    @(negedge clk);
    sb.push_back('{8'h81, 8'h81, cyc});
    data_mosi = 8'h7E;
    n = 0;
    while (!spi_cs_n && n < 500) begin
      @(negedge clk);
      n++;
    end
    hi = 0;
    while (spi_cs_n && hi < 100) begin
      @(negedge clk);
      hi++;
    end
    sb.push_back('{8'h7E, 8'h7E, cyc});
    dv_mosi = 1'b0;
    check("cs_gap", hi, G);
    wait_done();

    repeat (20) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
